// File: rtl/random_range_gen_pkg.sv
// Shared types and constants for the random range generator.
// Holds the FSM state encoding, LFSR taps and rejection limit.
package random_range_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam int          DEFAULT_WIDTH = 16;
  localparam int          MAX_REJECTS   = 3;

endpackage

// File: rtl/random_range_gen_if.sv
// Request/response bundle between the game controller and the range generator.
// The controller side uses the master modport, the generator the slave modport.
interface random_range_gen_if #(
  parameter int WIDTH = random_range_pkg::DEFAULT_WIDTH
);

  logic             req;
  logic [WIDTH-1:0] min;
  logic [WIDTH-1:0] max;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] rand_out;

  modport master (output req, min, max, input ready, valid, rand_out);
  modport slave  (input req, min, max, output ready, valid, rand_out);

endinterface

// File: rtl/random_range_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); never enters the all-zero state.
// A zero SEED would lock up the register, so it is replaced by 1.
module lfsr16
  import random_range_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (reset) value <= SEED_EFF;
    else       value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/random_range_gen.sv
// Maps the LFSR value into [min, max] via a 16-step restoring modulo, behind a req/ready/valid handshake.
// Optional macro RANDOM_RANGE_GEN_REJECT_REPEAT_EN: re-draw results that repeat the previous output.
module random_range_gen
  import random_range_pkg::*;
#(
  parameter int          WIDTH = DEFAULT_WIDTH,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic               clk,
  input logic               reset,
  random_range_gen_if.slave bus
);

  localparam logic [WIDTH:0] SPAN_ONE  = (WIDTH + 1)'(1);
  localparam logic [WIDTH:0] SPAN_FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [4:0]     LAST_STEP = 5'(WIDTH - 1);

  state_t           state, next_state;
  logic [15:0]      lfsr_value;
  logic [4:0]       count;
  logic [WIDTH-1:0] dvd_q, rem_q, min_q, rand_q;
  logic [WIDTH-1:0] degen_result, rem_next, result;
  logic [WIDTH:0]   span_q, span_in, trial;
  logic             valid_q, accept, degenerate, last_step;
  logic             reject_now, reject_q;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  assign accept       = bus.req && (state == IDLE);
  assign span_in      = {1'b0, bus.max} - {1'b0, bus.min} + SPAN_ONE;
  assign degenerate   = (bus.max < bus.min) || (span_in == SPAN_ONE) || (span_in == SPAN_FULL);
  assign degen_result = ((bus.max >= bus.min) && (span_in == SPAN_FULL)) ? lfsr_value : bus.min;

  // Partial remainder stays below span, so it always fits WIDTH bits.
  assign trial     = {rem_q, dvd_q[WIDTH-1]};
  assign rem_next  = WIDTH'((trial >= span_q) ? (trial - span_q) : trial);
  assign last_step = (count == LAST_STEP);
  assign result    = rem_next + min_q;

  assign bus.ready    = reset || (state == IDLE);
  assign bus.valid    = valid_q;
  assign bus.rand_out = rand_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = degenerate ? DONE : DIVIDE;
      DIVIDE:  if (last_step) next_state = DONE;
      DONE:    next_state = reject_q ? DIVIDE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result and valid are registered on entry to DONE so both are visible during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      min_q   <= '0;
      span_q  <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            min_q  <= bus.min;
            span_q <= span_in;
            dvd_q  <= lfsr_value;
            rem_q  <= '0;
            count  <= '0;
            if (degenerate) begin
              rand_q  <= degen_result;
              valid_q <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          rem_q <= rem_next;
          dvd_q <= dvd_q << 1;
          count <= count + 5'd1;
          if (last_step && !reject_now) begin
            rand_q  <= result;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (reject_q) begin
            dvd_q <= lfsr_value;
            rem_q <= '0;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RANDOM_RANGE_GEN_REJECT_REPEAT_EN
  logic       have_prev;
  logic [1:0] rejects;

  assign reject_now = have_prev && (span_q > SPAN_ONE) && (result == rand_q) &&
                      (rejects < 2'(MAX_REJECTS));

  // A repeat is only judged once a result has been delivered since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_prev <= 1'b0;
      rejects   <= '0;
      reject_q  <= 1'b0;
    end else begin
      have_prev <= have_prev || valid_q;
      reject_q  <= (state == DIVIDE) && last_step && reject_now;
      if (accept)                            rejects <= '0;
      else if ((state == DONE) && reject_q)  rejects <= rejects + 2'd1;
    end
  end
`else
  assign reject_now = 1'b0;
  assign reject_q   = 1'b0;
`endif

endmodule

// File: tb/tb_random_range_gen.sv
// Self-checking bench for random_range_gen: directed plan cases, abort, randomized ranges, sustained stream.
// Expected values come from the modulo rule applied to a reference copy of the LFSR sequence.
module tb_random_range_gen;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          N_B2B = 4000;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_lfsr;

  random_range_gen_if #(.WIDTH(16)) bus ();

  random_range_gen #(.WIDTH(16), .SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR sequence: the value held before each edge is the dividend of an accept on that edge
  always @(posedge clk)
    model_lfsr <= reset ? SEED : ((model_lfsr >> 1) ^ (model_lfsr[0] ? 16'hB400 : 16'h0000));

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request at the current negedge; scramble min/max after accept; measure latency
  task automatic issue(input logic [15:0] mn, input logic [15:0] mx, output int lat,
                       output logic [15:0] val, output logic [15:0] dvd, output logic rdy_after);
    bus.req = 1'b1;
    bus.min = mn;
    bus.max = mx;
    dvd     = model_lfsr;
    @(negedge clk);
    bus.req   = 1'b0;
    rdy_after = bus.ready;
    bus.min   = 16'($urandom);
    bus.max   = 16'($urandom);
    lat = 1;
    while (bus.valid !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    val = bus.rand_out;
    if (bus.valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 1'b1;
    bus.min = 16'd0;
    bus.max = 16'd8;
    @(negedge clk);
    checks += 3;
    if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready); end
    if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid); end
    if (bus.rand_out !== 16'd0) begin errors++; $display("[TB] FAIL reset_rand_out: got %h expected 0", bus.rand_out); end
    reset   = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", bus.ready); end
    if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid: got %b expected 0", bus.valid); end
  endtask

  task automatic test_basic();
    logic [15:0] mins[5] = '{16'd0, 16'd3, 16'd5, 16'd10, 16'd0};
    logic [15:0] maxs[5] = '{16'd8, 16'd11, 16'd5, 16'd2, 16'hFFFF};
    logic [15:0] exps[5] = '{16'd4, 16'd7, 16'd5, 16'd10, 16'hACE1};
    int          lats[5] = '{17, 17, 1, 1, 1};
    int          lat;
    logic [15:0] val, dvd;
    logic        rdy;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      issue(mins[i], maxs[i], lat, val, dvd, rdy);
      checks += 3;
      if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL basic%0d_ready_low: got %b expected 0", i, rdy); end
      if (lat != lats[i]) begin errors++; $display("[TB] FAIL basic%0d_latency: got %0d expected %0d", i, lat, lats[i]); end
      if (val !== exps[i]) begin errors++; $display("[TB] FAIL basic%0d_value: got %h expected %h", i, val, exps[i]); end
      @(negedge clk);
      checks += 2;
      if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL basic%0d_pulse: got %b expected 0", i, bus.valid); end
      if (bus.rand_out !== exps[i]) begin errors++; $display("[TB] FAIL basic%0d_hold: got %h expected %h", i, bus.rand_out, exps[i]); end
    end
  endtask

  task automatic test_abort();
    int          lat;
    logic [15:0] val, dvd;
    logic        rdy;
    do_reset();
    bus.req = 1'b1;
    bus.min = 16'd0;
    bus.max = 16'd8;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready_in_reset: got %b expected 1", bus.ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 3;
    if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", bus.valid); end
    if (bus.rand_out !== 16'd0) begin errors++; $display("[TB] FAIL abort_rand_out: got %h expected 0", bus.rand_out); end
    if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 1", bus.ready); end
    issue(16'd0, 16'd8, lat, val, dvd, rdy);
    checks += 2;
    if (lat != 17) begin errors++; $display("[TB] FAIL abort_retry_latency: got %0d expected 17", lat); end
    if (val !== 16'd4) begin errors++; $display("[TB] FAIL abort_retry_value: got %h expected 4", val); end
  endtask

  task automatic test_random();
    int          lat, sel, span, exp_lat, r;
    logic [15:0] mn, mx, val, dvd, exp_val, prev;
    logic        rdy, have_prev;
    have_prev = 1'b0;
    prev      = '0;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        mn = 16'($urandom_range(1, 65535));
        mx = 16'($urandom_range(0, int'(mn) - 1));
      end else if (sel == 1) begin
        mn = 16'($urandom);
        mx = mn;
      end else if (sel == 2) begin
        mn = 16'h0000;
        mx = 16'hFFFF;
      end else if (sel < 6) begin
        mn = 16'($urandom_range(0, 65000));
        mx = mn + 16'($urandom_range(1, 20));
      end else begin
        mn = 16'($urandom_range(0, 30000));
        mx = 16'($urandom_range(int'(mn) + 1, 65535));
        if (mn == 16'h0000 && mx == 16'hFFFF) mx = 16'hFFFE;
      end
      issue(mn, mx, lat, val, dvd, rdy);
      span = int'(mx) - int'(mn) + 1;
      if (mx < mn || span == 1) begin
        exp_val = mn;
        exp_lat = 1;
      end else if (span == 65536) begin
        exp_val = dvd;
        exp_lat = 1;
      end else begin
        exp_val = 16'((int'(dvd) % span) + int'(mn));
        exp_lat = 17;
      end
`ifdef RANDOM_RANGE_GEN_REJECT_REPEAT_EN
      if (exp_lat == 17) begin
        r = (lat - 17) / 17;
        checks += 3;
        if (lat < 17 || (lat % 17) != 0 || r > 3) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected 17+17k", i, lat); end
        if (val < mn || val > mx) begin errors++; $display("[TB] FAIL rand%0d_range: got %h expected %h..%h", i, val, mn, mx); end
        if ((r == 0 && val !== exp_val) || (have_prev && r < 3 && val == prev)) begin
          errors++; $display("[TB] FAIL rand%0d_value: got %h expected %h (prev %h, rejects %0d)", i, val, exp_val, prev, r);
        end
      end else begin
        checks += 2;
        if (lat != exp_lat) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
        if (val !== exp_val) begin errors++; $display("[TB] FAIL rand%0d_value: got %h expected %h", i, val, exp_val); end
      end
`else
      r = 0;
      checks += 2;
      if (lat != exp_lat) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
      if (val !== exp_val) begin errors++; $display("[TB] FAIL rand%0d_value: got %h expected %h", i, val, exp_val); end
`endif
      prev      = val;
      have_prev = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int          hist[10];
    int          v;
    logic [15:0] exp_val;
    logic [15:0] q[$];
    foreach (hist[k]) hist[k] = 0;
    do_reset();
    bus.req = 1'b1;
    bus.min = 16'd1;
    bus.max = 16'd9;
`ifdef RANDOM_RANGE_GEN_REJECT_REPEAT_EN
    begin
      int   got, since, exhausted;
      logic have_prev;
      logic [15:0] prev;
      got = 0; since = 0; exhausted = 0; have_prev = 1'b0; prev = '0;
      while (got < N_B2B) begin
        @(negedge clk);
        since++;
        if (bus.valid === 1'b1) begin
          v = int'(bus.rand_out);
          checks += 2;
          if (v < 1 || v > 9) begin errors++; $display("[TB] FAIL b2b_range: got %0d expected 1..9", v); end
          else hist[v]++;
          if (have_prev && bus.rand_out == prev) begin
            if (since == 69) exhausted++;
            else begin errors++; $display("[TB] FAIL b2b_repeat: got %0d again after %0d cycles expected 69", v, since); end
          end
          prev = bus.rand_out; have_prev = 1'b1;
          since = 0;
          got++;
        end else if (since > 80) begin
          checks++; errors++;
          $display("[TB] FAIL b2b_timeout: got no valid in %0d cycles expected at most 69", since);
          break;
        end
      end
      $display("[TB] repeats after exhausted rejections: %0d", exhausted);
    end
`else
    begin
      int spurious;
      spurious = 0;
      for (int cyc = 0; cyc < N_B2B * 18; cyc++) begin
        if (cyc % 18 == 0) begin
          q.push_back(model_lfsr);
          checks++;
          if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_idle: cycle %0d got %b expected 1", cyc, bus.ready); end
        end
        if (cyc % 18 == 17) begin
          exp_val = 16'((int'(q.pop_front()) % 9) + 1);
          checks++;
          if (bus.valid !== 1'b1 || bus.rand_out !== exp_val || bus.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_result: cycle %0d got valid %b ready %b value %0d expected 1 0 %0d",
                     cyc, bus.valid, bus.ready, bus.rand_out, exp_val);
          end
          v = int'(bus.rand_out);
          if (v >= 1 && v <= 9) hist[v]++;
        end else if (bus.valid !== 1'b0) begin
          spurious++;
        end
        @(negedge clk);
      end
      checks++;
      if (spurious != 0) begin errors++; $display("[TB] FAIL b2b_spurious_valid: got %0d expected 0", spurious); end
    end
`endif
    bus.req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (hist[k] * 900 < N_B2B * 85 || hist[k] * 900 > N_B2B * 115) begin
        errors++;
        $display("[TB] FAIL b2b_histogram_%0d: got %0d expected %0d +/-15%%", k, hist[k], N_B2B / 9);
      end
    end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.min = '0;
    bus.max = '0;
    test_reset();
    test_basic();
    test_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
